// File: rtl/seq_dec_pkg.sv
// Mode constants, legality check and decode helper shared by the registered line decoder.
package seq_dec_pkg;

  localparam int unsigned MODE_PULSE = 0;
  localparam int unsigned MODE_HOLD  = 1;
  localparam int unsigned MAX_SEL_W  = 8;
  localparam int unsigned MAX_LINES  = 1 << MAX_SEL_W;

  // Bit 0 carries oor, bits [n:1] the lines; everything above n is zero.
  typedef logic [MAX_LINES+1:0] dec_vec_t;

  function automatic bit params_ok(input int unsigned sel_w, input int unsigned num_out,
                                   input int unsigned hold_mode, input int unsigned cnt_w);
    return (sel_w >= 1) && (sel_w <= MAX_SEL_W) && (num_out >= 2) &&
           (num_out <= (32'd1 << sel_w)) && (hold_mode <= MODE_HOLD) && (cnt_w >= 1);
  endfunction

  function automatic dec_vec_t onehot_dec(input int unsigned sel, input int unsigned n,
                                          input logic active_low);
    dec_vec_t mask;
    dec_vec_t hot;
    dec_vec_t lines;
    mask  = (dec_vec_t'(1) << n) - dec_vec_t'(1);
    hot   = (sel < n) ? (dec_vec_t'(1) << sel) : '0;
    lines = active_low ? (mask & ~hot) : hot;
    return {lines[MAX_LINES:0], (sel >= n)};
  endfunction

endpackage

// File: rtl/seq_line_decoder_if.sv
// Code-word stream in, decoded line stream out, plus error-counter access.
interface seq_line_decoder_if #(
  parameter int unsigned SEL_W   = 4,
  parameter int unsigned NUM_OUT = 10,
  parameter int unsigned CNT_W   = 8
);
  logic               in_valid;
  logic               in_ready;
  logic [SEL_W-1:0]   in_sel;
  logic               out_valid;
  logic               out_ready;
  logic [NUM_OUT-1:0] out_lines;
  logic               out_oor;
  logic [CNT_W-1:0]   err_cnt;
  logic               clr_err;

  modport master (
    output in_valid, in_sel, out_ready, clr_err,
    input  in_ready, out_valid, out_lines, out_oor, err_cnt
  );

  modport slave (
    input  in_valid, in_sel, out_ready, clr_err,
    output in_ready, out_valid, out_lines, out_oor, err_cnt
  );
endinterface

// File: rtl/dec_skid_buf.sv
// Two-entry valid/ready queue; head data, valid and ready all come straight from flops.
module dec_skid_buf #(
  parameter int unsigned W            = 2,
  parameter logic [W-1:0] IdleVal     = '0,
  parameter bit           ClearOnEmpty = 1'b1
) (
  input  logic         clk_i,
  input  logic         rst_ni,
  input  logic         in_valid_i,
  output logic         in_ready_o,
  input  logic [W-1:0] in_data_i,
  output logic         out_valid_o,
  input  logic         out_ready_i,
  output logic [W-1:0] out_data_o
);

  logic [W-1:0] hd_d, hd_q, tl_d, tl_q;
  logic         hv_d, hv_q, tv_d, tv_q;
  logic         rdy_d, rdy_q;
  logic         push, pop;

  assign push = in_valid_i & rdy_q;
  assign pop  = hv_q & out_ready_i;

  always_comb begin
    hd_d = hd_q;
    tl_d = tl_q;
    hv_d = hv_q;
    tv_d = tv_q;
    if (pop) begin
      if (tv_q) begin
        // Full queue: rdy_q is low, so no push can coincide here.
        hd_d = tl_q;
        tv_d = 1'b0;
      end else if (push) begin
        hd_d = in_data_i;
      end else begin
        hv_d = 1'b0;
        hd_d = ClearOnEmpty ? IdleVal : hd_q;
      end
    end else if (push) begin
      if (hv_q) begin
        tl_d = in_data_i;
        tv_d = 1'b1;
      end else begin
        hd_d = in_data_i;
        hv_d = 1'b1;
      end
    end
    rdy_d = ~tv_d;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      hd_q  <= IdleVal;
      tl_q  <= IdleVal;
      hv_q  <= 1'b0;
      tv_q  <= 1'b0;
      rdy_q <= 1'b0;
    end else begin
      hd_q  <= hd_d;
      tl_q  <= tl_d;
      hv_q  <= hv_d;
      tv_q  <= tv_d;
      rdy_q <= rdy_d;
    end
  end

  assign in_ready_o  = rdy_q;
  assign out_valid_o = hv_q;
  assign out_data_o  = hd_q;

endmodule

// File: rtl/seq_line_decoder.sv
// Registered N-to-M line decoder: decode at push, 2-entry skid queue, saturating oor counter.
module seq_line_decoder
  import seq_dec_pkg::*;
#(
  parameter int unsigned SEL_W      = 4,
  parameter int unsigned NUM_OUT    = 10,
  parameter bit          ACTIVE_LOW = 1'b1,
  parameter int unsigned HOLD_MODE  = MODE_PULSE,
  parameter int unsigned CNT_W      = 8
) (
  input logic               clk,
  input logic               rst_n,
  seq_line_decoder_if.slave bus
);

  localparam int unsigned      W         = NUM_OUT + 1;
  localparam logic [W-1:0]     IdleEntry = {{NUM_OUT{ACTIVE_LOW}}, 1'b0};
  localparam logic [CNT_W-1:0] CntMax    = '1;

  if (!params_ok(SEL_W, NUM_OUT, HOLD_MODE, CNT_W)) begin : gen_bad_params
    $error("seq_line_decoder: illegal parameter set");
  end

  dec_vec_t         dec_full;
  logic [W-1:0]     entry;
  logic [W-1:0]     head;
  logic             unused_dec;
  logic             push;
  logic [CNT_W-1:0] err_d, err_q;

  assign dec_full   = onehot_dec(32'(bus.in_sel), NUM_OUT, ACTIVE_LOW);
  assign entry      = dec_full[W-1:0];
  assign unused_dec = ^dec_full[MAX_LINES+1:W];
  assign push       = bus.in_valid & bus.in_ready;

  // PULSE mode reloads the idle entry on empty; HOLD keeps the last popped entry.
  dec_skid_buf #(
    .W            (W),
    .IdleVal      (IdleEntry),
    .ClearOnEmpty (HOLD_MODE == MODE_PULSE)
  ) u_skid (
    .clk_i       (clk),
    .rst_ni      (rst_n),
    .in_valid_i  (bus.in_valid),
    .in_ready_o  (bus.in_ready),
    .in_data_i   (entry),
    .out_valid_o (bus.out_valid),
    .out_ready_i (bus.out_ready),
    .out_data_o  (head)
  );

  assign bus.out_lines = head[W-1:1];
  assign bus.out_oor   = head[0];

  always_comb begin
    err_d = err_q;
    if (bus.clr_err) begin
      err_d = '0;
    end else if (push && entry[0] && (err_q != CntMax)) begin
      err_d = err_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err_q <= '0;
    end else begin
      err_q <= err_d;
    end
  end

  assign bus.err_cnt = err_q;

endmodule

// File: tb/tb_seq_line_decoder.sv
// Three decoder configurations driven by directed and random stimulus against a queue model.
module tb_seq_line_decoder;

  logic clk;
  logic rst_n;

  logic       iv   [3];
  logic [3:0] isel [3];
  logic       ordy [3];
  logic       clr  [3];
  logic       ir   [3];
  logic       ov   [3];
  logic [9:0] ol   [3];
  logic       oo   [3];
  logic [7:0] ec   [3];

  // Instance 0: PULSE, active-low. 1: HOLD, active-low, 2-bit counter. 2: PULSE, active-high.
  bit          al_k   [3] = '{1'b1, 1'b1, 1'b0};
  bit          hold_k [3] = '{1'b0, 1'b1, 1'b0};
  int unsigned cmax   [3] = '{255, 3, 255};

  int unsigned mq [3][$];
  int unsigned merr [3];
  int unsigned last [3];
  bit          have_last [3];
  bit          started;

  int n_tests = 0;
  int n_fail  = 0;

  seq_line_decoder_if #(.SEL_W(4), .NUM_OUT(10), .CNT_W(8)) if_a ();
  seq_line_decoder_if #(.SEL_W(4), .NUM_OUT(10), .CNT_W(2)) if_h ();
  seq_line_decoder_if #(.SEL_W(4), .NUM_OUT(10), .CNT_W(8)) if_r ();

  seq_line_decoder #(.SEL_W(4), .NUM_OUT(10), .ACTIVE_LOW(1'b1), .HOLD_MODE(0), .CNT_W(8))
    u_a (.clk(clk), .rst_n(rst_n), .bus(if_a.slave));
  seq_line_decoder #(.SEL_W(4), .NUM_OUT(10), .ACTIVE_LOW(1'b1), .HOLD_MODE(1), .CNT_W(2))
    u_h (.clk(clk), .rst_n(rst_n), .bus(if_h.slave));
  seq_line_decoder #(.SEL_W(4), .NUM_OUT(10), .ACTIVE_LOW(1'b0), .HOLD_MODE(0), .CNT_W(8))
    u_r (.clk(clk), .rst_n(rst_n), .bus(if_r.slave));

  assign if_a.in_valid = iv[0];
  assign if_a.in_sel = isel[0];
  assign if_a.out_ready = ordy[0];
  assign if_a.clr_err = clr[0];
  assign ir[0] = if_a.in_ready;
  assign ov[0] = if_a.out_valid;
  assign ol[0] = if_a.out_lines;
  assign oo[0] = if_a.out_oor;
  assign ec[0] = if_a.err_cnt;

  assign if_h.in_valid = iv[1];
  assign if_h.in_sel = isel[1];
  assign if_h.out_ready = ordy[1];
  assign if_h.clr_err = clr[1];
  assign ir[1] = if_h.in_ready;
  assign ov[1] = if_h.out_valid;
  assign ol[1] = if_h.out_lines;
  assign oo[1] = if_h.out_oor;
  assign ec[1] = 8'(if_h.err_cnt);

  assign if_r.in_valid = iv[2];
  assign if_r.in_sel = isel[2];
  assign if_r.out_ready = ordy[2];
  assign if_r.clr_err = clr[2];
  assign ir[2] = if_r.in_ready;
  assign ov[2] = if_r.out_valid;
  assign ol[2] = if_r.out_lines;
  assign oo[2] = if_r.out_oor;
  assign ec[2] = if_r.err_cnt;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, act, exp);
    end
  endtask

  // Lines for a code: a single selected bit (inverted when active-low), none when out of range.
  function automatic logic [9:0] ref_lines(input int k, input int unsigned code);
    logic [9:0] hot;
    hot = (code < 10) ? (10'd1 << code) : 10'd0;
    return al_k[k] ? ~hot : hot;
  endfunction

  task automatic model_reset();
    for (int k = 0; k < 3; k++) begin
      mq[k].delete();
      merr[k] = 0;
      have_last[k] = 1'b0;
    end
    started = 1'b0;
  endtask

  task automatic model_update();
    if (!rst_n) return;
    for (int k = 0; k < 3; k++) begin
      bit rdy, push, pop;
      rdy  = started && (mq[k].size() < 2);
      push = iv[k] && rdy;
      pop  = ordy[k] && (mq[k].size() != 0);
      if (clr[k]) merr[k] = 0;
      else if (push && (isel[k] >= 4'd10) && (merr[k] < cmax[k])) merr[k]++;
      if (pop) begin
        last[k] = mq[k].pop_front();
        have_last[k] = 1'b1;
      end
      if (push) mq[k].push_back(32'(isel[k]));
    end
    started = 1'b1;
  endtask

  task automatic model_check(input int k);
    logic [9:0] el;
    logic       eo;
    if (mq[k].size() != 0) begin
      el = ref_lines(k, mq[k][0]);
      eo = (mq[k][0] >= 10);
    end else if (hold_k[k] && have_last[k]) begin
      el = ref_lines(k, last[k]);
      eo = (last[k] >= 10);
    end else begin
      el = al_k[k] ? 10'h3FF : 10'h000;
      eo = 1'b0;
    end
    check_eq($sformatf("in_ready[%0d]", k), 32'(ir[k]), 32'(started && (mq[k].size() < 2)));
    check_eq($sformatf("out_valid[%0d]", k), 32'(ov[k]), 32'(mq[k].size() != 0));
    check_eq($sformatf("out_lines[%0d]", k), 32'(ol[k]), 32'(el));
    check_eq($sformatf("out_oor[%0d]", k), 32'(oo[k]), 32'(eo));
    check_eq($sformatf("err_cnt[%0d]", k), 32'(ec[k]), merr[k]);
    if (!al_k[k]) check_eq($sformatf("onehot[%0d]", k), 32'($countones(ol[k]) <= 1), 32'd1);
  endtask

  task automatic cycle();
    @(posedge clk);
    model_update();
    @(negedge clk);
    for (int k = 0; k < 3; k++) model_check(k);
  endtask

  task automatic drive(input int k, input bit v, input int unsigned sel, input bit r, input bit c);
    iv[k]   = v;
    isel[k] = 4'(sel);
    ordy[k] = r;
    clr[k]  = c;
  endtask

  initial begin
    logic [9:0] seen [3];
    int         got;
    bit         acc;

    rst_n = 1'b0;
    for (int k = 0; k < 3; k++) drive(k, 1'b0, 0, 1'b1, 1'b0);
    model_reset();
    repeat (2) cycle();

    // Reset state.
    check_eq("rst_in_ready", 32'(ir[0]), 32'd0);
    check_eq("rst_out_valid", 32'(ov[0]), 32'd0);
    check_eq("rst_lines_al", 32'(ol[0]), 32'h3FF);
    check_eq("rst_lines_ah", 32'(ol[2]), 32'h000);
    check_eq("rst_err_cnt", 32'(ec[0]), 32'd0);
    rst_n = 1'b1;
    cycle();
    check_eq("ready_after_rst", 32'(ir[0]), 32'd1);

    // Single code, then PULSE idle.
    drive(0, 1'b1, 3, 1'b1, 1'b0);
    cycle();
    check_eq("t1_valid", 32'(ov[0]), 32'd1);
    check_eq("t1_lines", 32'(ol[0]), 32'h3F7);
    check_eq("t1_oor", 32'(oo[0]), 32'd0);
    drive(0, 1'b0, 0, 1'b1, 1'b0);
    cycle();
    check_eq("t1_idle", 32'(ol[0]), 32'h3FF);

    // Top in-range code, then out-of-range code.
    drive(0, 1'b1, 9, 1'b1, 1'b0);
    cycle();
    check_eq("t2_lines9", 32'(ol[0]), 32'h1FF);
    check_eq("t2_oor9", 32'(oo[0]), 32'd0);
    drive(0, 1'b1, 12, 1'b1, 1'b0);
    cycle();
    check_eq("t2_lines12", 32'(ol[0]), 32'h3FF);
    check_eq("t2_oor12", 32'(oo[0]), 32'd1);
    check_eq("t2_err", 32'(ec[0]), 32'd1);
    drive(0, 1'b0, 0, 1'b1, 1'b0);
    cycle();

    // Back-pressure: fill the queue, hold the third code, then drain in order.
    drive(0, 1'b1, 0, 1'b0, 1'b0);
    cycle();
    check_eq("t3_ready_1", 32'(ir[0]), 32'd1);
    drive(0, 1'b1, 1, 1'b0, 1'b0);
    cycle();
    check_eq("t3_ready_2", 32'(ir[0]), 32'd0);
    drive(0, 1'b1, 2, 1'b0, 1'b0);
    repeat (2) cycle();
    check_eq("t3_stall_lines", 32'(ol[0]), 32'h3FE);
    ordy[0] = 1'b1;
    got = 0;
    for (int c = 0; c < 8; c++) begin
      if (ov[0]) begin
        if (got < 3) seen[got] = ol[0];
        got++;
      end
      acc = iv[0] && ir[0];
      cycle();
      if (acc) iv[0] = 1'b0;
    end
    check_eq("t3_count", 32'(got), 32'd3);
    check_eq("t3_first", 32'(seen[0]), 32'h3FE);
    check_eq("t3_second", 32'(seen[1]), 32'h3FD);
    check_eq("t3_third", 32'(seen[2]), 32'h3FB);

    // HOLD mode keeps the last popped entry; async reset clears it at once.
    drive(1, 1'b1, 5, 1'b1, 1'b0);
    cycle();
    check_eq("t4_lines5", 32'(ol[1]), 32'h3DF);
    drive(1, 1'b0, 0, 1'b1, 1'b0);
    repeat (2) cycle();
    check_eq("t4_hold_valid", 32'(ov[1]), 32'd0);
    check_eq("t4_hold_lines", 32'(ol[1]), 32'h3DF);
    drive(1, 1'b1, 7, 1'b0, 1'b0);
    cycle();
    check_eq("t4_lines7", 32'(ol[1]), 32'h37F);
    drive(1, 1'b0, 0, 1'b0, 1'b0);
    cycle();
    #2 rst_n = 1'b0;
    model_reset();
    #1;
    check_eq("t4_rst_lines", 32'(ol[1]), 32'h3FF);
    check_eq("t4_rst_valid", 32'(ov[1]), 32'd0);
    cycle();
    rst_n = 1'b1;
    drive(1, 1'b0, 0, 1'b1, 1'b0);
    cycle();

    // Saturating 2-bit counter, clear wins over a coincident out-of-range push.
    drive(1, 1'b1, 15, 1'b1, 1'b0);
    for (int i = 0; i < 5; i++) begin
      cycle();
      check_eq($sformatf("t5_err_%0d", i), 32'(ec[1]), (i < 3) ? 32'(i + 1) : 32'd3);
    end
    check_eq("t5_oor", 32'(oo[1]), 32'd1);
    drive(1, 1'b1, 15, 1'b1, 1'b1);
    cycle();
    check_eq("t5_clr", 32'(ec[1]), 32'd0);
    drive(1, 1'b0, 0, 1'b1, 1'b0);
    cycle();

    // Random traffic on all three configurations, with one mid-run reset.
    for (int i = 0; i < 10000; i++) begin
      for (int k = 0; k < 3; k++) begin
        drive(k, $urandom_range(0, 3) != 0, $urandom_range(0, 15),
              $urandom_range(0, 1) != 0, $urandom_range(0, 15) == 0);
      end
      if (i == 5003) rst_n = 1'b1;
      if (i == 5000) begin
        #2 rst_n = 1'b0;
        model_reset();
      end
      cycle();
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
